// File: rtl/delivery_frame_serializer.sv
// Snapshots the game state on start and streams HEADER, status, ROWS row bytes and an XOR
// checksum over a valid/ready byte interface, leaving one idle cycle between bytes.
module delivery_frame_serializer #(
  parameter int unsigned ROWS   = 32,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [511:0] map_obstacles_flat,
  input  logic [511:0] map_objectives_flat,
  input  logic [3:0]   player_position,
  input  logic [2:0]   pontuacao,
  input  logic         game_over,
  input  logic         tx_ready,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  output logic         busy,
  output logic         done
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_STAT = 3'd2;
  localparam logic [2:0] S_ROW  = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;
  localparam logic [6:0] LAST_IDX = 7'(ROWS - 1);

  logic [2:0]   state_q, state_d;
  logic [6:0]   idx_q, idx_d;
  logic [7:0]   csum_q, csum_d;
  logic [511:0] obs_q, obs_d;
  logic [511:0] obj_q, obj_d;
  logic [7:0]   status_q, status_d;
  logic         tx_valid_q, tx_valid_d;
  logic [7:0]   tx_data_q, tx_data_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [7:0]   cur_byte_s;
  logic         xfer_s;

  function automatic logic [7:0] row_byte(input logic [511:0] obj, input logic [511:0] obs,
                                          input logic [6:0] idx);
    return {obj[{idx, 2'b00} +: 4], obs[{idx, 2'b00} +: 4]};
  endfunction

  assign xfer_s = tx_valid_q & tx_ready;

  // Byte the current state offers on the link
  always_comb begin
    cur_byte_s = 8'h00;
    case (state_q)
      S_HDR:   cur_byte_s = HEADER;
      S_STAT:  cur_byte_s = status_q;
      S_ROW:   cur_byte_s = row_byte(obj_q, obs_q, idx_q);
      S_CSUM:  cur_byte_s = csum_q;
      default: cur_byte_s = 8'h00;
    endcase
  end

  // Frame sequencing: present a byte, hold it while stalled, drop valid for a cycle after a transfer
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    obs_d      = obs_q;
    obj_d      = obj_q;
    status_d   = status_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          obs_d      = map_obstacles_flat;
          obj_d      = map_objectives_flat;
          status_d   = {game_over, pontuacao, player_position};
          csum_d     = 8'h00;
          idx_d      = 7'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = HEADER;
          busy_d     = 1'b1;
          state_d    = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR, S_STAT, S_ROW, S_CSUM: begin
        if (xfer_s) begin
          tx_valid_d = 1'b0;
          case (state_q)
            S_HDR: state_d = S_STAT;
            S_STAT: begin
              csum_d  = csum_q ^ cur_byte_s;
              state_d = S_ROW;
            end
            S_ROW: begin
              csum_d = csum_q ^ cur_byte_s;
              if (idx_q == LAST_IDX) begin
                state_d = S_CSUM;
              end else begin
                idx_d = idx_q + 7'd1;
              end
            end
            S_CSUM: begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_FIN;
            end
            default: state_d = S_IDLE;
          endcase
        end else if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_data_d  = cur_byte_s;
        end else begin
          tx_valid_d = 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 7'd0;
      csum_q     <= 8'h00;
      obs_q      <= '0;
      obj_q      <= '0;
      status_q   <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      obs_q      <= obs_d;
      obj_q      <= obj_d;
      status_q   <= status_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule
